// File: rtl/dcache_pkg.sv
// Shared types and widths for the dcache bank port arbiter.
//   DCACHE_ADDR_W / DCACHE_DATA_W : bank address and line widths
//   req_id_e                      : requester identifiers (also the grant_id encoding)
//   ret_tag_t                     : read-return tag carried alongside an issued access
package dcache_pkg;

  localparam int unsigned DCACHE_ADDR_W = 10;
  localparam int unsigned DCACHE_DATA_W = 18;

  typedef enum logic [1:0] {
    REQ_ST = 2'd0,
    REQ_LD = 2'd1,
    REQ_DW = 2'd2,
    REQ_DR = 2'd3
  } req_id_e;

  typedef struct packed {
    logic valid;
    logic is_dma;
  } ret_tag_t;

endpackage

// File: rtl/dcache_age_counter.sv
// Saturating wait counter for one DMA requester.
//   clk, rst_n   : clock, async active-low reset
//   i_freeze     : global stall, counter holds
//   i_valid      : requester valid
//   i_grant      : requester granted this cycle
//   o_promote_c  : counter has reached STARVE_MAX (combinational from the count)
module dcache_age_counter #(
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_freeze,
  input  logic i_valid,
  input  logic i_grant,
  output logic o_promote_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  // Count cycles spent waiting; any idle or granted cycle restarts aging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_freeze) begin
      if (!i_valid || i_grant) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_promote_c = (r_cnt == CNT_MAX);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates cisa store/load and DMA write/read onto one single-ported dcache bank
// and returns read data in order to the originating reader.
//   clk, rst_n                        : clock, async active-low reset
//   i_freeze                          : global stall (no grants, all state holds)
//   i_st_* / i_ld_* / i_dw_* / i_dr_* : requester valid/addr/wdata, o_*_ready grants
//   o_ld_rvalid/o_ld_rdata            : cisa load return
//   o_dr_rvalid/o_dr_rdata            : DMA read return
//   o_mem_*, i_mem_rdata              : bank port (1-cycle registered read)
//   o_grant_id                        : last granted requester (debug)
module dcache_port_arbiter
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = DCACHE_ADDR_W,
  parameter int unsigned DATA_W     = DCACHE_DATA_W,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_freeze,
  input  logic              i_st_valid,
  output logic              o_st_ready,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_wdata,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic              i_dw_valid,
  output logic              o_dw_ready,
  input  logic [ADDR_W-1:0] i_dw_addr,
  input  logic [DATA_W-1:0] i_dw_wdata,
  input  logic              i_dr_valid,
  output logic              o_dr_ready,
  input  logic [ADDR_W-1:0] i_dr_addr,
  output logic              o_ld_rvalid,
  output logic [DATA_W-1:0] o_ld_rdata,
  output logic              o_dr_rvalid,
  output logic [DATA_W-1:0] o_dr_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_grant_id
);

  logic [3:0]        w_gnt;
  req_id_e           w_gnt_id;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_dw_promote;
  logic              w_dr_promote;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  req_id_e           r_grant_id;
  ret_tag_t          r_tag_s1;
  ret_tag_t          r_tag_s2;
  logic              r_ld_rvalid;
  logic [DATA_W-1:0] r_ld_rdata;
  logic              r_dr_rvalid;
  logic [DATA_W-1:0] r_dr_rdata;

  dcache_age_counter #(.STARVE_MAX(STARVE_MAX)) u_age_dw (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_freeze    (i_freeze),
    .i_valid     (i_dw_valid),
    .i_grant     (w_gnt[REQ_DW]),
    .o_promote_c (w_dw_promote)
  );

  dcache_age_counter #(.STARVE_MAX(STARVE_MAX)) u_age_dr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_freeze    (i_freeze),
    .i_valid     (i_dr_valid),
    .i_grant     (w_gnt[REQ_DR]),
    .o_promote_c (w_dr_promote)
  );

  // Priority select: starved DMA (dw first) overrides st > ld > dw > dr.
  always_comb begin
    w_gnt    = '0;
    w_gnt_id = REQ_ST;
    if (rst_n && !i_freeze) begin
      if (i_dw_valid && w_dw_promote) begin
        w_gnt_id = REQ_DW;
      end else if (i_dr_valid && w_dr_promote) begin
        w_gnt_id = REQ_DR;
      end else if (i_st_valid) begin
        w_gnt_id = REQ_ST;
      end else if (i_ld_valid) begin
        w_gnt_id = REQ_LD;
      end else if (i_dw_valid) begin
        w_gnt_id = REQ_DW;
      end else begin
        w_gnt_id = REQ_DR;
      end
      w_gnt[w_gnt_id] = (w_gnt_id == REQ_ST) ? i_st_valid :
                        (w_gnt_id == REQ_LD) ? i_ld_valid :
                        (w_gnt_id == REQ_DW) ? i_dw_valid : i_dr_valid;
    end
    w_any = |w_gnt;

    case (w_gnt_id)
      REQ_ST: begin
        w_we    = 1'b1;
        w_addr  = i_st_addr;
        w_wdata = i_st_wdata;
      end
      REQ_LD: begin
        w_we    = 1'b0;
        w_addr  = i_ld_addr;
        w_wdata = '0;
      end
      REQ_DW: begin
        w_we    = 1'b1;
        w_addr  = i_dw_addr;
        w_wdata = i_dw_wdata;
      end
      default: begin
        w_we    = 1'b0;
        w_addr  = i_dr_addr;
        w_wdata = '0;
      end
    endcase
  end

  // Issue stage, two-deep return tag pipeline and read-return capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_grant_id  <= REQ_ST;
      r_tag_s1    <= '0;
      r_tag_s2    <= '0;
      r_ld_rvalid <= 1'b0;
      r_ld_rdata  <= '0;
      r_dr_rvalid <= 1'b0;
      r_dr_rdata  <= '0;
    end else if (!i_freeze) begin
      r_mem_en <= w_any;
      r_mem_we <= w_any && w_we;
      if (w_any) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
        r_grant_id  <= w_gnt_id;
      end
      r_tag_s1    <= '{valid: w_any && !w_we, is_dma: (w_gnt_id == REQ_DR)};
      r_tag_s2    <= r_tag_s1;
      r_ld_rvalid <= r_tag_s2.valid && !r_tag_s2.is_dma;
      r_dr_rvalid <= r_tag_s2.valid && r_tag_s2.is_dma;
      if (r_tag_s2.valid && !r_tag_s2.is_dma) begin
        r_ld_rdata <= i_mem_rdata;
      end
      if (r_tag_s2.valid && r_tag_s2.is_dma) begin
        r_dr_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_st_ready  = w_gnt[REQ_ST];
  assign o_ld_ready  = w_gnt[REQ_LD];
  assign o_dw_ready  = w_gnt[REQ_DW];
  assign o_dr_ready  = w_gnt[REQ_DR];
  // A frozen cycle must not touch the bank even with an access staged.
  assign o_mem_en    = r_mem_en && !i_freeze;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_grant_id  = r_grant_id;
  assign o_ld_rvalid = r_ld_rvalid;
  assign o_ld_rdata  = r_ld_rdata;
  assign o_dr_rvalid = r_dr_rvalid;
  assign o_dr_rdata  = r_dr_rdata;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a behavioural 1024x18 bank.
module tb_dcache_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 18;

  logic          clk;
  logic          rst_n;
  logic          freeze;
  logic          st_valid, st_ready, ld_valid, ld_ready;
  logic          dw_valid, dw_ready, dr_valid, dr_ready;
  logic [AW-1:0] st_addr, ld_addr, dw_addr, dr_addr;
  logic [DW-1:0] st_wdata, dw_wdata;
  logic          ld_rvalid, dr_rvalid;
  logic [DW-1:0] ld_rdata, dr_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant_id;

  logic [DW-1:0] ram [1024];

  int n_checks = 0;
  int n_errors = 0;

  dcache_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_freeze    (freeze),
    .i_st_valid  (st_valid),
    .o_st_ready  (st_ready),
    .i_st_addr   (st_addr),
    .i_st_wdata  (st_wdata),
    .i_ld_valid  (ld_valid),
    .o_ld_ready  (ld_ready),
    .i_ld_addr   (ld_addr),
    .i_dw_valid  (dw_valid),
    .o_dw_ready  (dw_ready),
    .i_dw_addr   (dw_addr),
    .i_dw_wdata  (dw_wdata),
    .i_dr_valid  (dr_valid),
    .o_dr_ready  (dr_ready),
    .i_dr_addr   (dr_addr),
    .o_ld_rvalid (ld_rvalid),
    .o_ld_rdata  (ld_rdata),
    .o_dr_rvalid (dr_rvalid),
    .o_dr_rdata  (dr_rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported bank with registered read; output holds when not enabled.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rdy();
    return 32'({dr_ready, dw_ready, ld_ready, st_ready});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) ram[i] = DW'(18'h10 + i);
    ram[10'h21] = 18'h3AB;
    ram[10'h23] = 18'h155;
    mem_rdata = '0;
    rst_n = 1'b1; freeze = 1'b0;
    st_valid = 0; ld_valid = 0; dw_valid = 0; dr_valid = 0;
    st_addr = '0; ld_addr = '0; dw_addr = '0; dr_addr = '0;
    st_wdata = '0; dw_wdata = '0;
    #1 rst_n = 1'b0;

    // Reset state
    tick; tick;
    chk("rst mem_en", 32'(mem_en), 0);
    chk("rst grant_id", 32'(grant_id), 0);
    chk("rst ld_rvalid", 32'(ld_rvalid), 0);
    st_valid = 1; ld_valid = 1;
    #1 chk("rst ready", rdy(), 0);
    st_valid = 0; ld_valid = 0;
    rst_n = 1'b1;
    tick;

    // 1: store then load to the same address
    st_valid = 1; st_addr = 10'd5; st_wdata = 18'h2A5;
    #1 chk("t1 st_ready", 32'(st_ready), 1);
    tick;
    st_valid = 0; ld_valid = 1; ld_addr = 10'd5;
    #1 chk("t1 ld_ready", 32'(ld_ready), 1);
    chk("t1 wr en", 32'(mem_en), 1);
    chk("t1 wr we", 32'(mem_we), 1);
    chk("t1 wr addr", 32'(mem_addr), 5);
    chk("t1 wr data", 32'(mem_wdata), 32'h2A5);
    chk("t1 gid st", 32'(grant_id), 0);
    tick;
    ld_valid = 0;
    chk("t1 rd en", 32'(mem_en), 1);
    chk("t1 rd we", 32'(mem_we), 0);
    chk("t1 rd addr", 32'(mem_addr), 5);
    chk("t1 gid ld", 32'(grant_id), 1);
    tick;
    chk("t1 idle en", 32'(mem_en), 0);
    chk("t1 early rvalid", 32'(ld_rvalid), 0);
    tick;
    chk("t1 rvalid", 32'(ld_rvalid), 1);
    chk("t1 rdata", 32'(ld_rdata), 32'h2A5);
    tick;
    chk("t1 rvalid pulse", 32'(ld_rvalid), 0);
    chk("t1 rdata hold", 32'(ld_rdata), 32'h2A5);

    // 2: all four requesters at once
    st_valid = 1; st_addr = 10'h20; st_wdata = 18'h111;
    ld_valid = 1; ld_addr = 10'h21;
    dw_valid = 1; dw_addr = 10'h22; dw_wdata = 18'h222;
    dr_valid = 1; dr_addr = 10'h23;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2 ready", rdy(), 32'(1) << i);
      if (i > 0) chk("t2 grant_id", 32'(grant_id), 32'(i - 1));
      tick;
      case (i)
        0: st_valid = 0;
        1: ld_valid = 0;
        2: dw_valid = 0;
        default: dr_valid = 0;
      endcase
    end
    chk("t2 grant_id dr", 32'(grant_id), 3);
    chk("t2 ld_rvalid", 32'(ld_rvalid), 1);
    chk("t2 ld_rdata", 32'(ld_rdata), 32'h3AB);
    chk("t2 dr_rvalid early", 32'(dr_rvalid), 0);
    tick;
    chk("t2 ld_rvalid off", 32'(ld_rvalid), 0);
    tick;
    chk("t2 dr_rvalid", 32'(dr_rvalid), 1);
    chk("t2 dr_rdata", 32'(dr_rdata), 32'h155);
    tick;
    chk("t2 dr_rvalid off", 32'(dr_rvalid), 0);
    chk("t2 st written", 32'(ram[10'h20]), 32'h111);
    chk("t2 dw written", 32'(ram[10'h22]), 32'h222);

    // 3: continuous loads starve dr until promotion
    ld_valid = 1; ld_addr = 10'h30;
    dr_valid = 1; dr_addr = 10'h31;
    for (int k = 0; k < 7; k++) begin
      #1 chk("t3 ld wins", rdy(), 32'h2);
      tick;
    end
    #1 chk("t3 dr promoted", rdy(), 32'h8);
    chk("t3 dr count max", 32'(dut.u_age_dr.r_cnt), 7);
    tick;
    dr_valid = 0;
    #1 chk("t3 ld regranted", rdy(), 32'h2);
    chk("t3 dr count clr", 32'(dut.u_age_dr.r_cnt), 0);
    chk("t3 gid dr", 32'(grant_id), 3);
    tick;
    ld_valid = 0;
    tick; tick; tick; tick;

    // 7: both DMA promoted together, dw first then dr
    st_valid = 1; st_addr = 10'h40; st_wdata = 18'h7;
    dw_valid = 1; dw_addr = 10'h41; dw_wdata = 18'h9;
    dr_valid = 1; dr_addr = 10'h42;
    for (int k = 0; k < 7; k++) begin
      #1 chk("t7 st wins", rdy(), 32'h1);
      tick;
    end
    #1 chk("t7 dw promoted", rdy(), 32'h4);
    tick;
    dw_valid = 0;
    #1 chk("t7 dr promoted", rdy(), 32'h8);
    tick;
    dr_valid = 0;
    #1 chk("t7 st back", rdy(), 32'h1);
    tick;
    st_valid = 0;
    tick; tick; tick; tick;

    // 4: freeze with a load in flight
    ld_valid = 1; ld_addr = 10'h21;
    #1 chk("t4 ld_ready", 32'(ld_ready), 1);
    tick;
    ld_valid = 0; freeze = 1;
    st_valid = 1; st_addr = 10'h50; st_wdata = 18'h1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t4 frozen mem_en", 32'(mem_en), 0);
      chk("t4 frozen ready", rdy(), 0);
      chk("t4 frozen rvalid", 32'(ld_rvalid), 0);
      tick;
    end
    freeze = 0; st_valid = 0;
    #1 chk("t4 thaw mem_en", 32'(mem_en), 1);
    chk("t4 thaw addr", 32'(mem_addr), 32'h21);
    chk("t4 thaw we", 32'(mem_we), 0);
    tick;
    chk("t4 rvalid early", 32'(ld_rvalid), 0);
    tick;
    chk("t4 rvalid", 32'(ld_rvalid), 1);
    chk("t4 rdata", 32'(ld_rdata), 32'h3AB);
    freeze = 1;
    tick;
    chk("t4 rvalid held", 32'(ld_rvalid), 1);
    freeze = 0;
    tick;
    chk("t4 rvalid off", 32'(ld_rvalid), 0);

    // 5: async reset with a load in flight
    ld_valid = 1; ld_addr = 10'd5;
    #1 chk("t5 ld_ready", 32'(ld_ready), 1);
    tick;
    ld_valid = 0;
    #1 chk("t5 pre mem_en", 32'(mem_en), 1);
    #1 rst_n = 1'b0;
    #1 chk("t5 async mem_en", 32'(mem_en), 0);
    chk("t5 async addr", 32'(mem_addr), 0);
    chk("t5 async gid", 32'(grant_id), 0);
    chk("t5 async rdata", 32'(ld_rdata), 0);
    ld_valid = 1;
    #1 chk("t5 rst ready", rdy(), 0);
    ld_valid = 0;
    tick; tick;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t5 no rvalid", 32'(ld_rvalid), 0);
      tick;
    end

    // 6: back-to-back DMA reads
    for (int j = 0; j < 8; j++) begin
      dr_valid = (j < 4);
      dr_addr  = AW'(j);
      #1;
      if (j < 4) chk("t6 dr_ready", 32'(dr_ready), 1);
      chk("t6 dr_rvalid", 32'(dr_rvalid), 32'(j >= 3 && j <= 6));
      if (j >= 3 && j <= 6) chk("t6 dr_rdata", 32'(dr_rdata), 32'(18'h10 + j - 3));
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
Sequences one single-ported dcache bank: one 1024x18 RAM, with write-or-read per cycle and 1-cycle registered read.
Arbitrates four requesters onto that single port: cisa store, cisa load, DMA write and DMA read.
Uses fixed priority plus an aging counter so DMA traffic cannot starve behind CISA traffic.
Returns read data in order to the originating read requester. Sits between regfile/DMA pipeline stages and the bank.

Parameters:
ADDR_W, 10, bank address width (1024 lines)
DATA_W, 18, line width (cherryfloat element)
STARVE_MAX, 7, wait cycles after which a pending DMA request is promoted above CISA requests
CNT_W, $clog2(STARVE_MAX+1), aging counter width (derived)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low (0 = in reset)
freeze  in  1  global pipeline stall
st_valid, st_ready  in/out  1  cisa store handshake; st_addr in ADDR_W; st_wdata in DATA_W
ld_valid, ld_ready  in/out  1  cisa load handshake; ld_addr in ADDR_W
dw_valid, dw_ready  in/out  1  DMA write handshake; dw_addr in ADDR_W; dw_wdata in DATA_W
dr_valid, dr_ready  in/out  1  DMA read handshake; dr_addr in ADDR_W
ld_rvalid, ld_rdata  out  1, DATA_W  load return
dr_rvalid, dr_rdata  out  1, DATA_W  DMA read return
mem_en, mem_we  out  1  bank enable / write enable
mem_addr  out  ADDR_W  bank address
mem_wdata  out  DATA_W  bank write data
mem_rdata  in  DATA_W  bank read data, valid 1 cycle after an enabled read
grant_id  out  2  last granted requester (0 st, 1 ld, 2 dw, 3 dr), debug

Behaviour:
- Reset (reset==0, async): every output register, aging counter and return-tag pipeline cleared to 0.
  - *_ready are 0 while in reset. In-flight reads are dropped, so no rvalid appears after release.
- Handshake:
  - A request transfers in a cycle where valid&ready.
  - The requester holds valid, addr and wdata stable until ready.
  - Ready is combinational from the valids, one-hot or zero. At most one grant per cycle.
- Priority: st > ld > dw > dr (base order).
  - A DMA requester whose counter == STARVE_MAX goes above both CISA requesters.
  - If both DMA requesters are promoted, dw wins.
- Aging counters (dw, dr):
  - Increment each unfrozen cycle where valid && !ready, saturating at STARVE_MAX.
  - Clear on grant, or in any cycle valid==0.
- freeze==1:
  - All *_ready = 0; all registers hold; mem_en forced 0 combinationally.
  - rvalid/rdata hold their values. Consumers are frozen too.
- Issue: a grant in cycle N registers mem_addr, mem_we and mem_wdata (0 for reads), mem_en=1 and a return tag.
  - These drive the bank in cycle N+1. mem_en deasserts the next cycle if there is no grant.
- Read latency:
  - Bank data is valid on mem_rdata in cycle N+2 and is registered into ld_rdata/dr_rdata.
  - The matching *_rvalid pulses high for exactly cycle N+3 (3 unfrozen cycles after handshake).
  - Reads without a grant leave rdata unchanged.
- Ordering:
  - Port accesses occur strictly in grant order.
  - A read granted after a write to the same address returns the new data. No forwarding is needed.
- Throughput:
  - Back-to-back grants every cycle.
  - ld and dr returns may each pulse every cycle, and at most one return fires per cycle.
- Write data width is exact. No arithmetic on data; address passes through unmodified.

Decomposition:
- Shared package (dcache_pkg):
  - requester id enum (REQ_ST=0, REQ_LD=1, REQ_DW=2, REQ_DR=3)
  - DCACHE_ADDR_W=10, DCACHE_DATA_W=18
  - return-tag typedef {valid, is_dma}
- One natural sub-module: dcache_age_counter (saturating wait counter with promote flag), instantiated for dw and dr.
- Priority select and return pipeline stay in the top module.

Test Plan:
1. st addr 5 data 0x2A5 granted, then ld addr 5 next cycle → mem_we=1 then 0 at addr 5; ld_rvalid exactly 3 cycles after ld handshake, ld_rdata=0x2A5.
2. All four valid in the same cycle, held → grants st, ld, dw, dr on 4 consecutive cycles; grant_id 0,1,2,3; dr_rvalid 3 cycles after its grant.
3. ld valid every cycle plus dr valid, STARVE_MAX=7 → dr granted in its 8th waiting cycle, ld regranted next cycle; dr counter back to 0.
4. Read in flight, freeze high 5 cycles after handshake → mem_en=0 and readies 0 throughout; rvalid appears after exactly 3 unfrozen cycles with correct data.
5. reset driven 0 asynchronously mid-cycle with a load in flight → all outputs 0 immediately without a clock edge; no ld_rvalid after release.
6. dr reads to addrs 0..3 preloaded 0x10..0x13, back-to-back → dr_rvalid high 4 consecutive cycles, dr_rdata 0x10, 0x11, 0x12, 0x13 in order.
